// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives {x,y,z} through 000..111 for a run of letra codes,
// samples the function block's s output and emits one 8-bit truth-table word per code.
module truth_table_sweeper #(
    parameter int         N_FUNCS   = 2,
    parameter logic [3:0] FIRST_SEL = 4'hA,
    parameter int         SETTLE    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       w,
    output logic [3:0] letra,
    output logic [7:0] table_out,
    output logic [3:0] table_sel,
    output logic       table_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SAMPLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [3:0] LAST_FUNC  = 4'(N_FUNCS - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] xyz_q, xyz_d;
    logic [3:0] func_q, func_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] cap_q, cap_d;
    logic [3:0] letra_q, letra_d;
    logic [7:0] tout_q, tout_d;
    logic [3:0] tsel_q, tsel_d;
    logic       tvalid_q, tvalid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            xyz_q    <= 3'd0;
            func_q   <= 4'd0;
            cnt_q    <= 4'd0;
            cap_q    <= 8'd0;
            letra_q  <= FIRST_SEL;
            tout_q   <= 8'd0;
            tsel_q   <= 4'd0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xyz_q    <= xyz_d;
            func_q   <= func_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            letra_q  <= letra_d;
            tout_q   <= tout_d;
            tsel_q   <= tsel_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Pulses default low; everything else holds unless a state updates it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xyz_d    = xyz_q;
        func_d   = func_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        letra_d  = letra_q;
        tout_d   = tout_q;
        tsel_d   = tsel_q;
        tvalid_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    idx_d   = 3'd0;
                    xyz_d   = 3'd0;
                    letra_d = FIRST_SEL;
                    func_d  = 4'd0;
                    cap_d   = 8'd0;
                    cnt_d   = SETTLE_CNT;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cap_d[idx_q] = s;
                if (idx_q == 3'd7) begin
                    state_d = EMIT;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    xyz_d   = idx_q + 3'd1;
                    cnt_d   = SETTLE_CNT;
                    state_d = WAIT;
                end
            end
            // cap_q already holds the idx 7 sample written on the preceding edge.
            EMIT: begin
                tout_d   = cap_q;
                tsel_d   = letra_q;
                tvalid_d = 1'b1;
                if (func_q == LAST_FUNC) begin
                    state_d = DONE;
                end else begin
                    func_d  = func_q + 4'd1;
                    letra_d = letra_q + 4'd1;
                    idx_d   = 3'd0;
                    xyz_d   = 3'd0;
                    cap_d   = 8'd0;
                    cnt_d   = SETTLE_CNT;
                    state_d = WAIT;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x           = xyz_q[2];
    assign y           = xyz_q[1];
    assign z           = xyz_q[0];
    assign w           = 1'b0;
    assign letra       = letra_q;
    assign table_out   = tout_q;
    assign table_sel   = tsel_q;
    assign table_valid = tvalid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
